// File: rtl/fir_i2s_tx_if.sv
// Sample/serial bundle between the FIR side and the I2S transmitter.
// The master is the FIR side: it presents the run request and the current
// filter output and receives the sample tick plus the I2S wire signals.
interface fir_i2s_tx_if #(
    parameter int DATA_WIDTH = 24
);
    logic                  en;
    logic [DATA_WIDTH-1:0] data;
    logic                  sample_tick;
    logic                  busy;
    logic                  bclk;
    logic                  lrclk;
    logic                  sdata;

    modport master (
        output en, data,
        input  sample_tick, busy, bclk, lrclk, sdata
    );

    modport slave (
        input  en, data,
        output sample_tick, busy, bclk, lrclk, sdata
    );
endinterface

// File: rtl/fir_i2s_tx.sv
// I2S transmitter and sample-rate master for a mono FIR output.
// The same captured sample is sent MSB first in both the left and the right
// slot, and one sample tick is issued per frame so that the filter advances
// in lock-step with the I2S frame rate.
// All outputs are registered from the next-state values, so every output
// lines up with the counter state that is held during the same clock cycle.
module fir_i2s_tx #(
    parameter int DATA_WIDTH = 24,
    parameter int SLOT_WIDTH = 32,
    parameter int BCLK_HALF  = 4
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    fir_i2s_tx_if.slave    bus
);
    localparam int K_W   = $clog2(2 * SLOT_WIDTH);
    localparam int DIV_W = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;

    localparam logic [K_W-1:0]   K_LAST   = K_W'(2 * SLOT_WIDTH - 1);
    localparam logic [K_W-1:0]   K_SLOT   = K_W'(SLOT_WIDTH);
    localparam logic [K_W-1:0]   LR_FIRST = K_W'(SLOT_WIDTH - 1);
    localparam logic [K_W-1:0]   LR_LAST  = K_W'(2 * SLOT_WIDTH - 2);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_HALF - 1);

    generate
        if (SLOT_WIDTH < DATA_WIDTH || BCLK_HALF < 1) begin : g_bad_params
            $error("fir_i2s_tx: need SLOT_WIDTH >= DATA_WIDTH and BCLK_HALF >= 1");
        end
    endgenerate

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [K_W-1:0]        k_q, k_d;
    logic [DIV_W-1:0]      div_q, div_d;
    logic                  half_q, half_d;
    logic [DATA_WIDTH-1:0] sample_q, sample_d;
    logic                  tick_q, tick_d;
    logic                  busy_q, busy_d;
    logic                  bclk_q, bclk_d;
    logic                  lrclk_q, lrclk_d;
    logic                  sdata_q, sdata_d;

    logic                  entering;
    logic [K_W-1:0]        slot_pos;
    logic [DATA_WIDTH-1:0] shifted;

    // Next state: bit-clock divider, bit counter, FSM and sample capture.
    // The run request is judged on the edge that starts the last clock of a
    // frame; that decision is carried by tick_q, so the frame-end edge
    // captures and continues exactly when a tick was issued, and stops
    // otherwise.
    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        div_d    = div_q;
        half_d   = half_q;
        sample_d = sample_q;
        entering = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.en) begin
                    state_d  = RUN;
                    sample_d = bus.data;
                    k_d      = '0;
                    div_d    = '0;
                    half_d   = 1'b0;
                    entering = 1'b1;
                end
            end
            RUN: begin
                if (div_q == DIV_LAST) begin
                    div_d  = '0;
                    half_d = ~half_q;
                    if (half_q) begin
                        if (k_q == K_LAST) begin
                            k_d = '0;
                            if (tick_q) begin
                                sample_d = bus.data;
                            end else begin
                                state_d = IDLE;
                            end
                        end else begin
                            k_d = k_q + 1'b1;
                        end
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output decode from the next state; a left shift by the slot position
    // brings the wanted bit to the MSB and yields zero padding past the word.
    always_comb begin
        slot_pos = (k_d >= K_SLOT) ? (k_d - K_SLOT) : k_d;
        shifted  = sample_d << slot_pos;
        busy_d   = (state_d == RUN);
        bclk_d   = busy_d & half_d;
        lrclk_d  = busy_d & (k_d >= LR_FIRST) & (k_d <= LR_LAST);
        sdata_d  = busy_d & shifted[DATA_WIDTH-1];
        tick_d   = entering |
                   (busy_d & bus.en & (k_d == K_LAST) & half_d & (div_d == DIV_LAST));
    end

    // State and registered outputs; reset drops everything immediately.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= IDLE;
            k_q      <= '0;
            div_q    <= '0;
            half_q   <= 1'b0;
            sample_q <= '0;
            tick_q   <= 1'b0;
            busy_q   <= 1'b0;
            bclk_q   <= 1'b0;
            lrclk_q  <= 1'b0;
            sdata_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            div_q    <= div_d;
            half_q   <= half_d;
            sample_q <= sample_d;
            tick_q   <= tick_d;
            busy_q   <= busy_d;
            bclk_q   <= bclk_d;
            lrclk_q  <= lrclk_d;
            sdata_q  <= sdata_d;
        end
    end

    assign bus.sample_tick = tick_q;
    assign bus.busy        = busy_q;
    assign bus.bclk        = bclk_q;
    assign bus.lrclk       = lrclk_q;
    assign bus.sdata       = sdata_q;
endmodule

// File: tb/tb_fir_i2s_tx.sv
// Bench for fir_i2s_tx: table of samples with their expected 64-bit serial
// frames, queued when the sample is presented and compared when the frame
// has been received, plus hand-written stop and mid-frame reset sequences.
module tb_fir_i2s_tx;
    localparam int DW    = 24;
    localparam int SW    = 32;
    localparam int BH    = 2;
    localparam int FRAME = 4 * SW * BH;
    localparam logic [63:0] LR_WORD = 64'h00000001FFFFFFFE;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fir_i2s_tx_if #(.DATA_WIDTH(DW)) bus_if ();

    fir_i2s_tx #(
        .DATA_WIDTH(DW),
        .SLOT_WIDTH(SW),
        .BCLK_HALF (BH)
    ) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .bus    (bus_if)
    );

    typedef struct {
        logic [DW-1:0] data;
        logic [63:0]   word;
    } vec_t;

    vec_t        tbl [5];
    logic [63:0] exp_q [$];
    int          total = 0;
    int          bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end else begin
            $display("ok   %s value=%h", name, act);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [4:0] outs();
        return {bus_if.sample_tick, bus_if.busy, bus_if.bclk, bus_if.lrclk, bus_if.sdata};
    endfunction

    // One full frame, starting at its first cycle (caller has done the edge).
    task automatic run_frame(input int fidx, input bit first, input bit cont,
                             input logic [DW-1:0] nxt, input logic [63:0] nxt_word);
        logic [63:0] sd_w;
        logic [63:0] lr_w;
        logic [63:0] req_w;
        int          bclk_err;
        int          stab_err;
        int          tick_err;
        int          busy_err;
        logic        sd0;
        logic        lr0;
        logic        exp_tick;
        int          k;
        int          ph;
        sd_w = '0; lr_w = '0;
        bclk_err = 0; stab_err = 0; tick_err = 0; busy_err = 0;
        sd0 = 1'b0; lr0 = 1'b0;
        for (int c = 0; c < FRAME; c++) begin
            if (c > 0) step();
            k  = c / (2 * BH);
            ph = c % (2 * BH);
            if (bus_if.bclk !== (ph >= BH)) bclk_err++;
            if (bus_if.busy !== 1'b1) busy_err++;
            exp_tick = (first && c == 0) || (cont && c == FRAME - 1);
            if (bus_if.sample_tick !== exp_tick) tick_err++;
            if (ph == 0) begin
                sd0 = bus_if.sdata;
                lr0 = bus_if.lrclk;
            end else if (bus_if.sdata !== sd0 || bus_if.lrclk !== lr0) begin
                stab_err++;
            end
            if (ph == BH) begin
                sd_w[63-k] = bus_if.sdata;
                lr_w[63-k] = bus_if.lrclk;
            end
            if (cont && c == FRAME - 1) begin
                bus_if.data = nxt;
                exp_q.push_back(nxt_word);
            end else begin
                bus_if.data = DW'($urandom);
            end
            if (!cont && c == 40) bus_if.en = 1'b0;
        end
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL frame%0d_queue actual=empty required=entry", fidx);
        end else begin
            req_w = exp_q.pop_front();
            check($sformatf("frame%0d_sdata", fidx), sd_w, req_w);
        end
        check($sformatf("frame%0d_lrclk", fidx), lr_w, LR_WORD);
        check($sformatf("frame%0d_bclk_err", fidx), 64'(bclk_err), 64'd0);
        check($sformatf("frame%0d_stable_err", fidx), 64'(stab_err), 64'd0);
        check($sformatf("frame%0d_tick_err", fidx), 64'(tick_err), 64'd0);
        check($sformatf("frame%0d_busy_err", fidx), 64'(busy_err), 64'd0);
    endtask

    // Idle check after a stop: nothing may move for a while.
    task automatic check_idle(input string name);
        int err;
        err = 0;
        step();
        check({name, "_outs"}, 64'(outs()), 64'd0);
        for (int i = 0; i < 300; i++) begin
            step();
            if (outs() !== 5'd0) err++;
        end
        check({name, "_quiet_err"}, 64'(err), 64'd0);
    endtask

    initial begin
        tbl[0] = '{24'hA5F00F, 64'hA5F00F00_A5F00F00};
        tbl[1] = '{24'h800000, 64'h80000000_80000000};
        tbl[2] = '{24'hFFFFFF, 64'hFFFFFF00_FFFFFF00};
        tbl[3] = '{24'h000001, 64'h00000100_00000100};
        tbl[4] = '{24'h5A0FF0, 64'h5A0FF000_5A0FF000};

        bus_if.en   = 1'b0;
        bus_if.data = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outs", 64'(outs()), 64'd0);
        rst_n = 1'b1;
        step();
        check("idle_outs", 64'(outs()), 64'd0);

        // Continuous run over the table; last frame has i_en dropped at k=10.
        bus_if.en   = 1'b1;
        bus_if.data = tbl[0].data;
        exp_q.push_back(tbl[0].word);
        step();
        for (int f = 0; f < 5; f++) begin
            if (f > 0) step();
            if (f < 4) run_frame(f, f == 0, 1'b1, tbl[f+1].data, tbl[f+1].word);
            else       run_frame(f, 1'b0, 1'b0, '0, '0);
        end
        check_idle("stop");

        // Mid-frame reset at k=40, then restart from k=0.
        bus_if.en   = 1'b1;
        bus_if.data = 24'h3CC35A;
        step();
        for (int c = 1; c <= 160; c++) begin
            step();
            bus_if.data = DW'($urandom);
        end
        check("pre_reset_busy_lr", 64'({bus_if.busy, bus_if.lrclk}), 64'd3);
        rst_n = 1'b0;
        #1;
        check("reset_mid_outs", 64'(outs()), 64'd0);
        step();
        step();
        check("reset_hold_outs", 64'(outs()), 64'd0);
        exp_q.delete();
        rst_n       = 1'b1;
        bus_if.data = 24'hC0FFEE;
        exp_q.push_back(64'hC0FFEE00_C0FFEE00);
        step();
        run_frame(5, 1'b1, 1'b0, '0, '0);
        check_idle("restart_stop");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
